// File: rtl/spsram320x36_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single 1RW 320x36 SRAM,
// with address range checking, fixed-latency responses and a zero-fill engine.
module spsram320x36_arbiter #(
    parameter int DW    = 36,
    parameter int AW    = 9,
    parameter int DEPTH = 320
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_start,
    output logic          clr_busy,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_req_we,
    input  logic [AW-1:0] a_req_addr,
    input  logic [DW-1:0] a_req_wdata,
    output logic          a_rsp_valid,
    output logic          a_rsp_err,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_we,
    input  logic [AW-1:0] b_req_addr,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_rsp_valid,
    output logic          b_rsp_err,
    output logic [DW-1:0] b_rsp_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    typedef struct packed {
        logic valid;
        logic port;   // 0 = A, 1 = B
        logic we;
        logic err;
    } tag_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          rr_last_q, rr_last_d;   // 1 = B was granted last
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    tag_t          tag1_q, tag1_d, tag2_q;

    logic          gnt_a, gnt_b;
    logic          sel_we, sel_err;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rr_last_d  = rr_last_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        tag1_d     = '0;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                mem_en_d   = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = clr_addr_q;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = S_IDLE;
                    clr_addr_d = '0;
                end
            end
            S_IDLE: begin
                if (clr_start) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                end else begin
                    gnt_a = a_req_valid & (~b_req_valid | rr_last_q);
                    gnt_b = b_req_valid & ~gnt_a;
                end
            end
            default: state_d = S_IDLE;
        endcase

        sel_we    = gnt_b ? b_req_we    : a_req_we;
        sel_addr  = gnt_b ? b_req_addr  : a_req_addr;
        sel_wdata = gnt_b ? b_req_wdata : a_req_wdata;
        sel_err   = sel_addr > LAST_ADDR;

        // Out-of-range commands still occupy a pipeline slot so responses keep order.
        if (gnt_a | gnt_b) begin
            rr_last_d    = gnt_b;
            tag1_d.valid = 1'b1;
            tag1_d.port  = gnt_b;
            tag1_d.we    = sel_we;
            tag1_d.err   = sel_err;
            if (!sel_err) begin
                mem_en_d   = 1'b1;
                mem_we_d   = sel_we;
                mem_addr_d = sel_addr;
                mem_din_d  = sel_we ? sel_wdata : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            rr_last_q  <= 1'b1;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rr_last_q  <= rr_last_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
        end
    end

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;
    // The FSM already sits in CLEAR during reset; mask it so the flag reads 0 until release.
    assign clr_busy    = rst_n & (state_q == S_CLEAR);

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

    logic hit_a, hit_b, rd_ok;
    assign hit_a = tag2_q.valid & ~tag2_q.port;
    assign hit_b = tag2_q.valid &  tag2_q.port;
    assign rd_ok = ~tag2_q.we & ~tag2_q.err;

    assign a_rsp_valid = hit_a;
    assign a_rsp_err   = hit_a & tag2_q.err;
    assign a_rsp_rdata = (hit_a & rd_ok) ? mem_dout : '0;
    assign b_rsp_valid = hit_b;
    assign b_rsp_err   = hit_b & tag2_q.err;
    assign b_rsp_rdata = (hit_b & rd_ok) ? mem_dout : '0;

endmodule

// File: tb/tb_spsram320x36_arbiter.sv
// Bench for spsram320x36_arbiter: SRAM model plus a transaction-level reference
// (shadow array, grant rule, response queue) driven by tables, sequences and random traffic.
module tb_spsram320x36_arbiter;

    localparam int DEPTH = 320;

    logic        clk;
    logic        rst_n;
    logic        clr_start;
    logic        clr_busy;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [8:0]  a_req_addr;
    logic [35:0] a_req_wdata;
    logic        a_rsp_valid, a_rsp_err;
    logic [35:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [8:0]  b_req_addr;
    logic [35:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [35:0] b_rsp_rdata;
    logic        mem_en, mem_we;
    logic [8:0]  mem_addr;
    logic [35:0] mem_din;
    logic [35:0] mem_dout = '0;

    spsram320x36_arbiter #(.DW(36), .AW(9), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_err(a_rsp_err), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_err(b_rsp_err), .b_rsp_rdata(b_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model, seeded with garbage so the clear engine is actually exercised.
    logic [35:0] sram [DEPTH];
    bit seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= {4'h5, $urandom};
            seeded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                if (int'(mem_addr) < DEPTH) sram[mem_addr] <= mem_din;
            end else begin
                mem_dout <= (int'(mem_addr) < DEPTH) ? sram[mem_addr] : 36'hBAD_BAD_BAD;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        bit          port;
        bit          err;
        logic [35:0] data;
    } rsp_t;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [8:0]  addr;
        logic [35:0] din;
    } memcmd_t;

    logic [35:0] ref_mem [DEPTH];
    rsp_t        rq[$];
    memcmd_t     exp_mem;
    int          clear_left;
    int          clear_idx;
    bit          rr_b;
    int unsigned win;
    int          n_cmp, n_fail;
    logic        smp_ra, smp_rb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s win=%0d actual=%0h required=%0h", name, win, act, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        exp_mem    = '0;
        clear_left = DEPTH;
        clear_idx  = 0;
        rr_b       = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // One clock window: inputs already set; check, advance the model, step the clock.
    task automatic cycle();
        bit          busy, ea, eb, port, we;
        logic [8:0]  ad;
        logic [35:0] wd;
        logic [37:0] exp_a, exp_b;
        rsp_t        r;
        memcmd_t     nxt;
        #1;
        busy = (clear_left > 0);
        ea = 1'b0;
        eb = 1'b0;
        if (!busy && !clr_start) begin
            if (a_req_valid && (!b_req_valid || rr_b)) ea = 1'b1;
            else if (b_req_valid) eb = 1'b1;
        end
        chk("a_ready", 64'(a_req_ready), 64'(ea));
        chk("b_ready", 64'(b_req_ready), 64'(eb));
        chk("clr_busy", 64'(clr_busy), 64'(busy));
        if (exp_mem.en)
            chk("mem_cmd", 64'({mem_en, mem_we, mem_addr, mem_we ? mem_din : 36'd0}), 64'(exp_mem));
        else
            chk("mem_idle", 64'({mem_en, mem_we}), 64'd0);

        exp_a = '0;
        exp_b = '0;
        if (rq.size() > 0 && rq[0].due == win) begin
            r = rq.pop_front();
            if (r.port) exp_b = {1'b1, r.err, r.data};
            else        exp_a = {1'b1, r.err, r.data};
        end
        chk("a_rsp", 64'({a_rsp_valid, a_rsp_err, a_rsp_rdata}), 64'(exp_a));
        chk("b_rsp", 64'({b_rsp_valid, b_rsp_err, b_rsp_rdata}), 64'(exp_b));

        nxt = '0;
        if (busy) begin
            nxt = {1'b1, 1'b1, 9'(clear_idx), 36'd0};
            clear_idx++;
            clear_left--;
        end else if (clr_start) begin
            clear_left = DEPTH;
            clear_idx  = 0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (ea || eb) begin
            port = eb;
            we   = eb ? b_req_we    : a_req_we;
            ad   = eb ? b_req_addr  : a_req_addr;
            wd   = eb ? b_req_wdata : a_req_wdata;
            rr_b = eb;
            if (int'(ad) >= DEPTH) begin
                rq.push_back('{win + 2, port, 1'b1, 36'd0});
            end else if (we) begin
                ref_mem[ad] = wd;
                nxt = {1'b1, 1'b1, ad, wd};
                rq.push_back('{win + 2, port, 1'b0, 36'd0});
            end else begin
                nxt = {1'b1, 1'b0, ad, 36'd0};
                rq.push_back('{win + 2, port, 1'b0, ref_mem[ad]});
            end
        end
        exp_mem = nxt;
        smp_ra  = a_req_ready;
        smp_rb  = b_req_ready;
        @(posedge clk);
        @(negedge clk);
        win++;
    endtask

    task automatic idle_inputs();
        a_req_valid = 1'b0; b_req_valid = 1'b0; clr_start = 1'b0;
        a_req_we = 1'b0; b_req_we = 1'b0;
        a_req_addr = '0; b_req_addr = '0; a_req_wdata = '0; b_req_wdata = '0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctl", 64'({a_req_ready, b_req_ready, clr_busy, a_rsp_valid, b_rsp_valid,
                            a_rsp_err, b_rsp_err, mem_en, mem_we}), 64'd0);
        chk("rst_data", 64'(a_rsp_rdata | b_rsp_rdata | mem_din | 36'(mem_addr)), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_a(input bit v, input bit we, input int ad, input logic [35:0] wd);
        a_req_valid = v; a_req_we = we; a_req_addr = 9'(ad); a_req_wdata = wd;
    endtask

    task automatic set_b(input bit v, input bit we, input int ad, input logic [35:0] wd);
        b_req_valid = v; b_req_we = we; b_req_addr = 9'(ad); b_req_wdata = wd;
    endtask

    typedef struct {
        bit av;
        bit bv;
        bit exp_ra;
        bit exp_rb;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL watchdog win=%0d actual=timeout required=finish", win);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit prev_a;
        n_cmp = 0;
        n_fail = 0;
        win = 0;
        // Arbitration table starting from the post-reset priority (B last, so A wins a tie).
        tbl[0] = '{1, 1, 1, 0};
        tbl[1] = '{1, 1, 0, 1};
        tbl[2] = '{1, 0, 1, 0};
        tbl[3] = '{1, 0, 1, 0};
        tbl[4] = '{1, 1, 0, 1};
        tbl[5] = '{0, 1, 0, 1};
        tbl[6] = '{1, 1, 1, 0};
        tbl[7] = '{0, 0, 0, 0};
        tbl[8] = '{1, 1, 0, 1};

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        model_reset();

        // Power-up clear: 320 writes of zero at 0..319.
        repeat (DEPTH) cycle();

        // Table: reads of addresses 5 (A) and 7 (B) post-clear return 0.
        for (int i = 0; i < 9; i++) begin
            set_a(tbl[i].av, 1'b0, 5, '0);
            set_b(tbl[i].bv, 1'b0, 7, '0);
            cycle();
            chk("tbl_ra", 64'(smp_ra), 64'(tbl[i].exp_ra));
            chk("tbl_rb", 64'(smp_rb), 64'(tbl[i].exp_rb));
        end
        idle_inputs();
        repeat (2) cycle();

        // Write then read-back on consecutive cycles.
        set_a(1, 1, 10, 36'hABCDE);
        cycle();
        chk("raw_wr_ready", 64'(smp_ra), 64'd1);
        set_a(1, 0, 10, '0);
        cycle();
        chk("raw_rd_ready", 64'(smp_ra), 64'd1);
        idle_inputs();
        repeat (3) cycle();

        // Both ports saturated: grants must alternate.
        prev_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_a(1, 0, i % 8, '0);
            set_b(1, 1, i % 8, {4'hC, $urandom});
            cycle();
            chk("fair_one_grant", 64'(smp_ra ^ smp_rb), 64'd1);
            if (i > 0) chk("fair_alternate", 64'(smp_ra), 64'(!prev_a));
            prev_a = smp_ra;
        end
        idle_inputs();
        repeat (3) cycle();

        // Out-of-range reads on B.
        set_b(1, 0, 320, '0);
        cycle();
        set_b(1, 0, 511, '0);
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Clear while A is waiting: blocked for the start cycle plus 320 clear cycles.
        set_a(1, 0, 10, '0);
        clr_start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            clr_start = 1'b0;
            if (smp_ra) break;
            cnt++;
        end
        chk("clr_block_len", 64'(cnt), 64'd321);
        idle_inputs();
        repeat (3) cycle();

        // Reset one cycle after an accepted read: its response must vanish.
        set_a(1, 0, 10, '0);
        cycle();
        do_reset();
        repeat (DEPTH) cycle();

        // Random traffic, mostly a small address window to hit read-after-write.
        for (int i = 0; i < 500; i++) begin
            int ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 15);
            rb = ($urandom_range(0, 7) == 0) ? $urandom_range(318, 511) : $urandom_range(0, 15);
            set_a($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra, {4'h1, $urandom});
            set_b($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rb, {4'h2, $urandom});
            clr_start = ($urandom_range(0, 199) == 0);
            cycle();
        end
        idle_inputs();
        while (clear_left > 0) cycle();
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
